// File: rtl/i2c_codec_reg_slave_if.sv
// Debug/observation bundle of the WM8731-style I2C register target.
// The slave drives the decoded register view and commit info; the master observes it.
interface i2c_codec_reg_slave_if;
    logic [8:0] l_vol;
    logic [8:0] r_vol;
    logic       codec_active;
    logic       wr_strobe;
    logic [6:0] wr_reg;
    logic [8:0] wr_data;
    logic [7:0] write_count;
    logic [3:0] testbit;

    modport slave (
        output l_vol, r_vol, codec_active, wr_strobe,
        output wr_reg, wr_data, write_count, testbit
    );

    modport master (
        input l_vol, r_vol, codec_active, wr_strobe,
        input wr_reg, wr_data, write_count, testbit
    );
endinterface

// File: rtl/i2c_codec_reg_slave.sv
// WM8731-style write-only I2C control-port target (3-byte frames).
// Define I2C_GLITCH_FILT_EN to add a 3-sample majority filter on SCL/SDA.
module i2c_codec_reg_slave #(
    parameter logic [6:0] DEV_ADDR = 7'h1A,
    parameter int         NUM_REGS = 10
) (
    input  logic clk_i2c,
    input  logic reset_n,
    input  logic I2C_SCLK,
    inout  wire  I2C_SDAT,
    i2c_codec_reg_slave_if.slave dbg
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        ADDR   = 4'd1,
        ACK0   = 4'd2,
        BYTE1  = 4'd3,
        ACK1   = 4'd4,
        BYTE2  = 4'd5,
        ACK2   = 4'd6,
        IGNORE = 4'd7
    } state_t;

    function automatic logic [8:0] reg_default(int i);
        case (i)
            0, 1:    return 9'h097;
            2, 3:    return 9'h079;
            4:       return 9'h00A;
            5:       return 9'h008;
            6:       return 9'h09F;
            7:       return 9'h00A;
            default: return 9'h000;
        endcase
    endfunction

    state_t     state, nxt;
    logic [1:0] scl_sy, sda_sy;
    logic       scl_c, sda_c;
    logic       scl_p, sda_p;
    logic       scl_rise, scl_fall;
    logic       start_ev, stop_ev;
    logic [3:0] cnt;
    logic [7:0] sh;
    logic [7:0] b1;
    logic       in_byte, byte_done;
    logic       addr_hit;
    logic       commit;
    logic       sda_low;
    logic [6:0] wreg;
    logic [8:0] wdat;
    logic       strobe_q;
    logic [6:0] wr_reg_q;
    logic [8:0] wr_data_q;
    logic [7:0] count_q;
    logic [8:0] regs [NUM_REGS];

    always_ff @(posedge clk_i2c or negedge reset_n) begin
        if (!reset_n) begin
            scl_sy <= 2'b11;
            sda_sy <= 2'b11;
        end else begin
            scl_sy <= {scl_sy[0], I2C_SCLK};
            sda_sy <= {sda_sy[0], I2C_SDAT};
        end
    end

`ifdef I2C_GLITCH_FILT_EN
    logic [2:0] scl_h, sda_h;

    always_ff @(posedge clk_i2c or negedge reset_n) begin
        if (!reset_n) begin
            scl_h <= 3'b111;
            sda_h <= 3'b111;
        end else begin
            scl_h <= {scl_h[1:0], scl_sy[1]};
            sda_h <= {sda_h[1:0], sda_sy[1]};
        end
    end

    assign scl_c = (scl_h[0] & scl_h[1]) | (scl_h[0] & scl_h[2])
                 | (scl_h[1] & scl_h[2]);
    assign sda_c = (sda_h[0] & sda_h[1]) | (sda_h[0] & sda_h[2])
                 | (sda_h[1] & sda_h[2]);
`else
    assign scl_c = scl_sy[1];
    assign sda_c = sda_sy[1];
`endif

    always_ff @(posedge clk_i2c or negedge reset_n) begin
        if (!reset_n) begin
            scl_p <= 1'b1;
            sda_p <= 1'b1;
        end else begin
            scl_p <= scl_c;
            sda_p <= sda_c;
        end
    end

    assign scl_rise  = scl_c & ~scl_p;
    assign scl_fall  = ~scl_c & scl_p;
    assign start_ev  = scl_c & scl_p & sda_p & ~sda_c;
    assign stop_ev   = scl_c & scl_p & ~sda_p & sda_c;
    assign in_byte   = (state == ADDR) || (state == BYTE1) || (state == BYTE2);
    assign byte_done = (cnt == 4'd8);
    assign addr_hit  = (sh[7:1] == DEV_ADDR) && !sh[0];
    assign wreg      = b1[7:1];
    assign wdat      = {b1[0], sh};

    always_ff @(posedge clk_i2c or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= nxt;
    end

    always_comb begin
        nxt     = state;
        commit  = 1'b0;
        sda_low = 1'b0;
        if (start_ev) begin
            nxt = ADDR;
        end else if (stop_ev) begin
            nxt = IDLE;
        end else begin
            unique case (state)
                ADDR:
                    if (scl_fall && byte_done)
                        nxt = addr_hit ? ACK0 : IGNORE;
                ACK0:  if (scl_fall) nxt = BYTE1;
                BYTE1: if (scl_fall && byte_done) nxt = ACK1;
                ACK1:  if (scl_fall) nxt = BYTE2;
                BYTE2: if (scl_fall && byte_done) nxt = ACK2;
                ACK2: begin
                    if (scl_fall) begin
                        nxt    = IGNORE;
                        commit = 1'b1;
                    end
                end
                default: nxt = state;
            endcase
        end
        // ACK is held straight from the state so reset releases SDA at once
        sda_low = (state == ACK0) || (state == ACK1) || (state == ACK2);
    end

    always_ff @(posedge clk_i2c or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= 4'd0;
            sh  <= 8'd0;
            b1  <= 8'd0;
        end else begin
            if (start_ev || nxt != state) begin
                cnt <= 4'd0;
            end else if (scl_rise && in_byte && !byte_done) begin
                sh  <= {sh[6:0], sda_c};
                cnt <= cnt + 4'd1;
            end
            if (state == BYTE1 && nxt == ACK1) b1 <= sh;
        end
    end

    always_ff @(posedge clk_i2c or negedge reset_n) begin
        if (!reset_n) begin
            strobe_q  <= 1'b0;
            wr_reg_q  <= 7'd0;
            wr_data_q <= 9'd0;
            count_q   <= 8'd0;
        end else begin
            strobe_q <= commit;
            if (commit) begin
                wr_reg_q  <= wreg;
                wr_data_q <= wdat;
                count_q   <= count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i2c or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= reg_default(i);
        end else if (commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wreg == 7'h0F)
                    regs[i] <= reg_default(i);
                else if (wreg == 7'(i))
                    regs[i] <= wdat;
            end
        end
    end

    if (NUM_REGS > 2) begin : g_lvol
        assign dbg.l_vol = regs[2];
    end else begin : g_lvol_def
        assign dbg.l_vol = 9'h079;
    end

    if (NUM_REGS > 3) begin : g_rvol
        assign dbg.r_vol = regs[3];
    end else begin : g_rvol_def
        assign dbg.r_vol = 9'h079;
    end

    if (NUM_REGS > 9) begin : g_act
        assign dbg.codec_active = regs[9][0];
    end else begin : g_act_def
        assign dbg.codec_active = 1'b0;
    end

    assign dbg.wr_strobe   = strobe_q;
    assign dbg.wr_reg      = wr_reg_q;
    assign dbg.wr_data     = wr_data_q;
    assign dbg.write_count = count_q;
    assign dbg.testbit     = state;
    assign I2C_SDAT        = sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_codec_reg_slave.sv
// Directed bench for the WM8731-style I2C register target.
// Bench-driven I2C master on a pulled-up open-drain SDA line.
module tb_i2c_codec_reg_slave;

    localparam int Q = 8;

    logic clk_i2c = 1'b0;
    logic reset_n = 1'b0;
    logic scl     = 1'b1;
    logic sda_lo  = 1'b0;
    wire  sda;

    pullup (sda);
    assign sda = sda_lo ? 1'b0 : 1'bz;

    i2c_codec_reg_slave_if dbg ();

    i2c_codec_reg_slave #(
        .DEV_ADDR(7'h1A),
        .NUM_REGS(10)
    ) dut (
        .clk_i2c (clk_i2c),
        .reset_n (reset_n),
        .I2C_SCLK(scl),
        .I2C_SDAT(sda),
        .dbg     (dbg)
    );

    always #5 clk_i2c = ~clk_i2c;

    int vectors     = 0;
    int miscompares = 0;
    int strobes     = 0;

    always @(posedge clk_i2c) if (dbg.wr_strobe === 1'b1) strobes++;

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i2c);
    endtask

    task automatic i2c_start;
        sda_lo = 1'b0; tick(Q);
        scl = 1'b1;    tick(Q);
        sda_lo = 1'b1; tick(Q);
        scl = 1'b0;    tick(Q);
    endtask

    task automatic i2c_stop;
        sda_lo = 1'b1; tick(Q);
        scl = 1'b1;    tick(Q);
        sda_lo = 1'b0; tick(2 * Q);
    endtask

    task automatic send_bit(input logic b);
        sda_lo = ~b; tick(Q);
        scl = 1'b1;  tick(2 * Q);
        scl = 1'b0;  tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_lo = 1'b0; tick(Q);
        scl = 1'b1;    tick(Q);
        ack = (sda === 1'b0);
        tick(Q);
        scl = 1'b0;    tick(Q);
    endtask

    task automatic write_frame(input logic [7:0] a, input logic [7:0] x,
                               input logic [7:0] y, output logic [2:0] acks);
        i2c_start();
        send_byte(a, acks[2]);
        send_byte(x, acks[1]);
        send_byte(y, acks[0]);
        i2c_stop();
    endtask

    task automatic do_reset;
        reset_n = 1'b0; tick(4);
        reset_n = 1'b1; tick(4);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick(3);
        vectors++;
        if (dbg.testbit !== 4'd0 || sda !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_state got st=%h sda=%b exp st=0 sda=1", dbg.testbit, sda);
        end
        vectors++;
        if (dbg.l_vol !== 9'h079 || dbg.r_vol !== 9'h079 || dbg.codec_active !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_regs got l=%h r=%h a=%b exp l=079 r=079 a=0",
                     dbg.l_vol, dbg.r_vol, dbg.codec_active);
        end
        vectors++;
        if (dbg.wr_strobe !== 1'b0 || dbg.wr_reg !== 7'd0 || dbg.wr_data !== 9'd0
            || dbg.write_count !== 8'd0) begin
            miscompares++;
            $display("FAIL rst_wr got s=%b reg=%h d=%h c=%0d exp all 0", dbg.wr_strobe,
                     dbg.wr_reg, dbg.wr_data, dbg.write_count);
        end
        reset_n = 1'b1;
        tick(4);
    endtask

    task automatic test_write_lvol;
        logic [2:0] acks;
        int s0;
        s0 = strobes;
        write_frame(8'h34, 8'h04, 8'h48, acks);
        vectors++;
        if (acks !== 3'b111) begin
            miscompares++;
            $display("FAIL lvol_acks got %b exp 111", acks);
        end
        vectors++;
        if (dbg.l_vol !== 9'h048 || dbg.r_vol !== 9'h079) begin
            miscompares++;
            $display("FAIL lvol_val got l=%h r=%h exp l=048 r=079", dbg.l_vol, dbg.r_vol);
        end
        vectors++;
        if (dbg.wr_reg !== 7'h02 || dbg.wr_data !== 9'h048) begin
            miscompares++;
            $display("FAIL lvol_wr got reg=%h d=%h exp reg=02 d=048", dbg.wr_reg, dbg.wr_data);
        end
        vectors++;
        if (strobes - s0 !== 1 || dbg.write_count !== 8'd1) begin
            miscompares++;
            $display("FAIL lvol_strobe got cycles=%0d cnt=%0d exp cycles=1 cnt=1",
                     strobes - s0, dbg.write_count);
        end
    endtask

    task automatic test_bit8;
        logic [2:0] acks;
        write_frame(8'h34, 8'h07, 8'hFF, acks);
        vectors++;
        if (dbg.r_vol !== 9'h1FF || dbg.l_vol !== 9'h048) begin
            miscompares++;
            $display("FAIL bit8_vol got r=%h l=%h exp r=1ff l=048", dbg.r_vol, dbg.l_vol);
        end
        vectors++;
        if (dbg.wr_reg !== 7'h03 || dbg.wr_data !== 9'h1FF || dbg.write_count !== 8'd2) begin
            miscompares++;
            $display("FAIL bit8_wr got reg=%h d=%h c=%0d exp reg=03 d=1ff c=2",
                     dbg.wr_reg, dbg.wr_data, dbg.write_count);
        end
    endtask

    task automatic test_wrong_addr;
        logic [2:0] acks;
        int s0;
        s0 = strobes;
        write_frame(8'h36, 8'h04, 8'h11, acks);
        vectors++;
        if (acks !== 3'b000) begin
            miscompares++;
            $display("FAIL waddr_acks got %b exp 000", acks);
        end
        vectors++;
        if (strobes != s0 || dbg.l_vol !== 9'h048 || dbg.write_count !== 8'd2) begin
            miscompares++;
            $display("FAIL waddr_side got strobes=%0d l=%h c=%0d exp strobes=0 l=048 c=2",
                     strobes - s0, dbg.l_vol, dbg.write_count);
        end
    endtask

    task automatic test_restore;
        logic [2:0] acks;
        do_reset();
        write_frame(8'h34, 8'h12, 8'h01, acks);
        vectors++;
        if (dbg.codec_active !== 1'b1 || dbg.write_count !== 8'd1) begin
            miscompares++;
            $display("FAIL act_set got a=%b c=%0d exp a=1 c=1", dbg.codec_active, dbg.write_count);
        end
        write_frame(8'h34, 8'h1E, 8'h00, acks);
        vectors++;
        if (acks !== 3'b111 || dbg.wr_reg !== 7'h0F) begin
            miscompares++;
            $display("FAIL restore_wr got acks=%b reg=%h exp acks=111 reg=0f", acks, dbg.wr_reg);
        end
        vectors++;
        if (dbg.l_vol !== 9'h079 || dbg.r_vol !== 9'h079 || dbg.codec_active !== 1'b0
            || dbg.write_count !== 8'd2) begin
            miscompares++;
            $display("FAIL restore_regs got l=%h r=%h a=%b c=%0d exp l=079 r=079 a=0 c=2",
                     dbg.l_vol, dbg.r_vol, dbg.codec_active, dbg.write_count);
        end
    endtask

    task automatic test_abort;
        logic a;
        int s0;
        s0 = strobes;
        i2c_start();
        send_byte(8'h34, a);
        send_byte(8'h04, a);
        i2c_stop();
        vectors++;
        if (strobes != s0 || dbg.l_vol !== 9'h079 || dbg.write_count !== 8'd2) begin
            miscompares++;
            $display("FAIL stop_abort got strobes=%0d l=%h c=%0d exp strobes=0 l=079 c=2",
                     strobes - s0, dbg.l_vol, dbg.write_count);
        end
        i2c_start();
        send_byte(8'h34, a);
        send_byte(8'h04, a);
        i2c_start();
        send_byte(8'h34, a);
        send_byte(8'h04, a);
        send_byte(8'h55, a);
        i2c_stop();
        vectors++;
        if (strobes - s0 != 1 || dbg.l_vol !== 9'h055 || dbg.write_count !== 8'd3) begin
            miscompares++;
            $display("FAIL rstart got strobes=%0d l=%h c=%0d exp strobes=1 l=055 c=3",
                     strobes - s0, dbg.l_vol, dbg.write_count);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic a;
        logic [2:0] acks;
        int s0;
        i2c_start();
        send_byte(8'h34, a);
        send_byte(8'h06, a);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        sda_lo = 1'b0;
        scl = 1'b1;
        tick(Q);
        vectors++;
        if (dbg.testbit !== 4'd5) begin
            miscompares++;
            $display("FAIL mid_state got %h exp 5", dbg.testbit);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (dbg.testbit !== 4'd0 || sda !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_rst got st=%h sda=%b exp st=0 sda=1", dbg.testbit, sda);
        end
        tick(2);
        vectors++;
        if (dbg.l_vol !== 9'h079 || dbg.write_count !== 8'd0 || dbg.wr_reg !== 7'd0
            || dbg.wr_data !== 9'd0) begin
            miscompares++;
            $display("FAIL mid_outs got l=%h c=%0d reg=%h d=%h exp l=079 c=0 reg=0 d=0",
                     dbg.l_vol, dbg.write_count, dbg.wr_reg, dbg.wr_data);
        end
        reset_n = 1'b1;
        tick(2);
        scl = 1'b0;
        tick(Q);
        i2c_stop();
        s0 = strobes;
        write_frame(8'h34, 8'h04, 8'h12, acks);
        vectors++;
        if (acks !== 3'b111 || dbg.l_vol !== 9'h012 || dbg.write_count !== 8'd1
            || strobes - s0 != 1) begin
            miscompares++;
            $display("FAIL post_rst got acks=%b l=%h c=%0d s=%0d exp acks=111 l=012 c=1 s=1",
                     acks, dbg.l_vol, dbg.write_count, strobes - s0);
        end
    endtask

    initial begin
        test_reset();
        test_write_lvol();
        test_bit8();
        test_wrong_addr();
        test_restore();
        test_abort();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
